// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// wait-state handling and timeout abort, with per-requester done/rdata/err.
module apb_master_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic              p_clk,
    input  logic              p_resetn,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,

    output logic              p_sel,
    output logic              p_enable,
    output logic              p_write,
    output logic [ADDR_W-1:0] p_addr,
    output logic [DATA_W-1:0] p_wdata,
    input  logic [DATA_W-1:0] p_rdata,
    input  logic              p_ready,
    input  logic              p_slverr
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    // Bit 1 drives p_sel, bit 0 drives p_enable, so both come straight from flops.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b10,
        ST_ACCESS = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_ptr;
    logic             r_owner;
    logic [TO_W-1:0]  r_to_cnt;
    cmd_t             r_cmd;
    logic             r_done0;
    logic             r_done1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic             r_err0;
    logic             r_err1;

    logic             w_arb_en;
    logic             w_complete;
    logic             w_timeout;
    logic             w_req0;
    logic             w_req1;
    logic             w_grant;
    logic             w_grant_id;
    cmd_t             w_cmd0;
    cmd_t             w_cmd1;
    cmd_t             w_win_cmd;

    assign w_cmd0    = '{write: req0_write, addr: req0_addr, wdata: req0_wdata};
    assign w_cmd1    = '{write: req1_write, addr: req1_addr, wdata: req1_wdata};
    assign w_win_cmd = w_grant_id ? w_cmd1 : w_cmd0;

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, completion/timeout decode and round-robin grant.
    always_comb begin
        w_next_state = r_state;
        w_arb_en     = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        w_grant      = 1'b0;
        w_grant_id   = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_arb_en = 1'b1;
            end
            ST_SETUP: begin
                w_next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (p_ready) begin
                    w_complete   = 1'b1;
                    w_arb_en     = 1'b1;
                    w_next_state = ST_IDLE;
                end else if ((TIMEOUT != 0) && (r_to_cnt == TO_LAST)) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // The owner of the transfer still in flight cannot win again.
        w_req0 = req0_valid && !((r_state == ST_ACCESS) && !r_owner);
        w_req1 = req1_valid && !((r_state == ST_ACCESS) &&  r_owner);

        if (w_arb_en && p_resetn && (w_req0 || w_req1)) begin
            w_grant      = 1'b1;
            w_grant_id   = (w_req0 && w_req1) ? r_ptr : w_req1;
            w_next_state = ST_SETUP;
            req0_ready   = !w_grant_id;
            req1_ready   =  w_grant_id;
        end
    end

    // Command capture, pointer, timeout counter and requester result registers.
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            r_ptr    <= 1'b0;
            r_owner  <= 1'b0;
            r_to_cnt <= '0;
            r_cmd    <= '0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;

            if (w_grant) begin
                r_ptr   <= !w_grant_id;
                r_owner <= w_grant_id;
                r_cmd   <= w_win_cmd;
            end

            if (w_next_state == ST_SETUP) begin
                r_to_cnt <= '0;
            end else if ((r_state == ST_ACCESS) && !p_ready) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            if (w_complete || w_timeout) begin
                if (!r_owner) begin
                    r_done0 <= 1'b1;
                    r_err0  <= w_timeout ? 1'b1 : p_slverr;
                    if (w_timeout) begin
                        r_rdata0 <= '0;
                    end else if (!r_cmd.write) begin
                        r_rdata0 <= p_rdata;
                    end
                end else begin
                    r_done1 <= 1'b1;
                    r_err1  <= w_timeout ? 1'b1 : p_slverr;
                    if (w_timeout) begin
                        r_rdata1 <= '0;
                    end else if (!r_cmd.write) begin
                        r_rdata1 <= p_rdata;
                    end
                end
            end
        end
    end

    assign p_sel      = r_state[1];
    assign p_enable   = r_state[0];
    assign p_write    = r_cmd.write;
    assign p_addr     = r_cmd.addr;
    assign p_wdata    = r_cmd.wdata;

    assign req0_done  = r_done0;
    assign req0_rdata = r_rdata0;
    assign req0_err   = r_err0;
    assign req1_done  = r_done1;
    assign req1_rdata = r_rdata1;
    assign req1_err   = r_err1;

endmodule
